// File: rtl/arbitro_antirebote_if.sv
// Button-side bundle of the shared debounce arbiter: raw levels in, press pulses,
// debounced levels and busy flag out.
interface arbitro_antirebote_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] pulse;
  logic [N_BTN-1:0] btn_estable;
  logic             busy;

  modport master (output btn_raw, input pulse, input btn_estable, input busy);
  modport slave  (input btn_raw, output pulse, output btn_estable, output busy);
endinterface

// File: rtl/arbitro_antirebote.sv
// Time-shared debounce: one settling counter granted round-robin to changed buttons.
// Optional autorepeat of the last pressed button is enabled with `define AUTOREPEAT_EN.
module arbitro_antirebote #(
  parameter int N_BTN         = 4,
  parameter int DEB_CYCLES    = 16,
  parameter int CNT_W         = 5,
  parameter int REPEAT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  arbitro_antirebote_if.slave bus
);

  localparam int SEL_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  if ((N_BTN < 2) || (N_BTN > 8) || (DEB_CYCLES < 2) ||
      ((1 << CNT_W) < DEB_CYCLES) || (REPEAT_CYCLES < 2)) begin : g_bad_params
    $error("arbitro_antirebote: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, COMMIT, ABORT} state_t;

  state_t           state, state_nxt;
  logic [N_BTN-1:0] sync1, sync2, req;
  logic [N_BTN-1:0] estable, estable_nxt;
  logic [N_BTN-1:0] pulse_r, pulse_nxt, rep_pulse;
  logic [SEL_W-1:0] sel, sel_nxt, sel_inc, rr_ptr, rr_nxt, grant_idx;
  logic             target, target_nxt, grant_found;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  int               rr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.btn_raw;
      sync2 <= sync1;
    end
  end

  assign req     = sync2 ^ estable;
  assign sel_inc = (sel == SEL_W'(N_BTN - 1)) ? '0 : sel + 1'b1;

  // First requesting button at or above rr_ptr, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_idx      = 0;
    for (int i = 0; i < N_BTN; i++) begin
      rr_idx = int'(rr_ptr) + i;
      if (rr_idx >= N_BTN) rr_idx = rr_idx - N_BTN;
      if (!grant_found && req[rr_idx]) begin
        grant_found = 1'b1;
        grant_idx   = SEL_W'(rr_idx);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    target_nxt  = target;
    cnt_nxt     = cnt;
    estable_nxt = estable;
    pulse_nxt   = '0;
    rr_nxt      = rr_ptr;
    case (state)
      IDLE: begin
        if (grant_found) begin
          sel_nxt    = grant_idx;
          target_nxt = sync2[grant_idx];
          cnt_nxt    = '0;
          state_nxt  = SETTLE;
        end
      end
      SETTLE: begin
        if (sync2[sel] != target) begin
          state_nxt = ABORT;
          rr_nxt    = sel_inc;
        end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
          // Outputs are registered on entry so they are valid during COMMIT.
          state_nxt        = COMMIT;
          estable_nxt[sel] = target;
          pulse_nxt[sel]   = target;
          rr_nxt           = sel_inc;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      COMMIT:  state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AUTOREPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;

  logic             rep_en, rep_en_nxt;
  logic [SEL_W-1:0] rep_sel, rep_sel_nxt;
  logic [REP_W-1:0] rep_tmr, rep_tmr_nxt;

  // The COMMIT cycle counts toward the period so repeats land REPEAT_CYCLES apart.
  always_comb begin
    rep_en_nxt  = rep_en;
    rep_sel_nxt = rep_sel;
    rep_tmr_nxt = rep_tmr;
    rep_pulse   = '0;
    if ((state == SETTLE) && (state_nxt == COMMIT)) begin
      rep_tmr_nxt = '0;
      if (target) begin
        rep_en_nxt  = 1'b1;
        rep_sel_nxt = sel;
      end else if (sel == rep_sel) begin
        rep_en_nxt = 1'b0;
      end
    end else if (rep_en && estable[rep_sel] && (req == '0) &&
                 ((state == IDLE) || (state == COMMIT))) begin
      if (rep_tmr == REP_W'(REPEAT_CYCLES - 1)) begin
        rep_tmr_nxt        = '0;
        rep_pulse[rep_sel] = 1'b1;
      end else begin
        rep_tmr_nxt = rep_tmr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_en  <= 1'b0;
      rep_sel <= '0;
      rep_tmr <= '0;
    end else begin
      rep_en  <= rep_en_nxt;
      rep_sel <= rep_sel_nxt;
      rep_tmr <= rep_tmr_nxt;
    end
  end
`else
  assign rep_pulse = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      target  <= 1'b0;
      cnt     <= '0;
      estable <= '0;
      pulse_r <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      target  <= target_nxt;
      cnt     <= cnt_nxt;
      estable <= estable_nxt;
      pulse_r <= pulse_nxt | rep_pulse;
      rr_ptr  <= rr_nxt;
    end
  end

  assign bus.pulse       = pulse_r;
  assign bus.btn_estable = estable;
  assign bus.busy        = (state != IDLE);

endmodule
